// File: rtl/npu_mac_pkg.sv
// Shared types and constants for the MAC datapath tail: sum widths, clip limits
// and the 14-bit to 13-bit saturation used by the collector and reference models.
package npu_mac_pkg;

  localparam int SUM_W = 14;
  localparam int OUT_W = 13;

  localparam logic signed [OUT_W-1:0] SAT_POS = 13'sh0FFF;
  localparam logic signed [OUT_W-1:0] SAT_NEG = 13'sh1000;

  typedef struct packed {
    logic                    sat;
    logic signed [OUT_W-1:0] data;
  } result_t;

  // Bits [13:12] carry the adder_final overflow code; 01/10 clip, 00/11 pass through.
  function automatic result_t sat(input logic [SUM_W-1:0] s);
    result_t r;
    case (s[SUM_W-1:SUM_W-2])
      2'b01: begin
        r.sat  = 1'b1;
        r.data = SAT_POS;
      end
      2'b10: begin
        r.sat  = 1'b1;
        r.data = SAT_NEG;
      end
      default: begin
        r.sat  = 1'b0;
        r.data = s[OUT_W-1:0];
      end
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mac_out_fifo.sv
// Small synchronous FIFO of retired results; head is presented combinationally
// from storage and every entry clears to zero on reset.
module mac_out_fifo
  import npu_mac_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic    clk,
  input  logic    reset,
  input  logic    push,
  input  result_t push_data,
  input  logic    pop,
  output result_t head,
  output logic    full,
  output logic    empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  result_t            mem [DEPTH];
  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W-1:0]   wr_ptr;
  logic [CNT_W-1:0]   count;
  logic               push_eff;
  logic               pop_eff;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full     = (count == CNT_W'(DEPTH));
  assign empty    = (count == '0);
  assign pop_eff  = pop && !empty;
  assign push_eff = push && !full;
  assign head     = mem[rd_ptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push_eff) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (pop_eff) rd_ptr <= ptr_inc(rd_ptr);
      case ({push_eff, pop_eff})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mac_accum_collector.sv
// Collects adder_final sums over PASSES passes, feeding the saturated partial back
// as pre_output and retiring each finished output into a small result buffer.
module mac_accum_collector
  import npu_mac_pkg::*;
#(
  parameter int PASSES = 3,
  parameter int DEPTH  = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [SUM_W-1:0]        sum_in,
  input  logic                    clear,
  output logic signed [OUT_W-1:0] pre_output,
  output logic [3:0]              pass_idx,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic signed [OUT_W-1:0] res_data,
  output logic                    res_sat
);

  logic [3:0]              pc;
  logic signed [OUT_W-1:0] acc;
  logic                    grp_sat;
  logic                    last;
  logic                    accept;
  logic                    push;
  logic                    fifo_full;
  logic                    fifo_empty;
  result_t                 cur;
  result_t                 push_data;
  result_t                 head;

  // Handshakes: a transfer happens on a rising edge where valid && ready; ready never
  // depends on the same-cycle valid, and in_ready ignores res_ready (pre-pop count).
  assign last      = (pc == 4'(PASSES - 1));
  assign in_ready  = !last || !fifo_full;
  assign accept    = in_valid && in_ready;
  assign push      = accept && last && !clear;
  assign cur       = sat(sum_in);

  always_comb begin
    push_data      = cur;
    push_data.sat  = grp_sat | cur.sat;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc      <= '0;
      acc     <= '0;
      grp_sat <= 1'b0;
    end else if (clear) begin
      pc      <= '0;
      acc     <= '0;
      grp_sat <= 1'b0;
    end else if (accept) begin
      if (last) begin
        pc      <= '0;
        acc     <= '0;
        grp_sat <= 1'b0;
      end else begin
        pc      <= pc + 1'b1;
        acc     <= cur.data;
        grp_sat <= grp_sat | cur.sat;
      end
    end
  end

  mac_out_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (push),
    .push_data(push_data),
    .pop      (res_ready),
    .head     (head),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  assign pre_output = acc;
  assign pass_idx   = pc;
  assign res_valid  = !fifo_empty;
  assign res_data   = head.data;
  assign res_sat    = head.sat;

endmodule

// File: tb/tb_mac_accum_collector.sv
// Directed bench for mac_accum_collector (PASSES=3, DEPTH=2) with hand-computed
// expectations; inputs change on the falling edge, outputs are checked just after.
module tb_mac_accum_collector;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [13:0] sum_in;
  logic        clear;
  logic [12:0] pre_output;
  logic [3:0]  pass_idx;
  logic        res_valid;
  logic        res_ready;
  logic [12:0] res_data;
  logic        res_sat;

  int pass_cnt;
  int total_cnt;

  mac_accum_collector #(
    .PASSES(3),
    .DEPTH (2)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sum_in    (sum_in),
    .clear     (clear),
    .pre_output(pre_output),
    .pass_idx  (pass_idx),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_sat   (res_sat)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // driver tasks
  task automatic put(input logic [13:0] s, input logic c);
    @(negedge clk);
    in_valid = 1'b1;
    sum_in   = s;
    clear    = c;
    #1;
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
    sum_in   = '0;
    clear    = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    total_cnt++; if (res_valid !== 1'b0) $display("FAIL reset_res_valid got=%0b exp=0", res_valid); else pass_cnt++;
    total_cnt++; if (pre_output !== 13'd0) $display("FAIL reset_pre_output got=%0d exp=0", pre_output); else pass_cnt++;
    total_cnt++; if (pass_idx !== 4'd0) $display("FAIL reset_pass_idx got=%0d exp=0", pass_idx); else pass_cnt++;
    total_cnt++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got=%0b exp=1", in_ready); else pass_cnt++;
    total_cnt++; if ({res_sat, res_data} !== 14'd0) $display("FAIL reset_res got=%h exp=0", {res_sat, res_data}); else pass_cnt++;
  endtask

  task automatic test_basic();
    res_ready = 1'b1;
    put(14'd10, 1'b0);
    total_cnt++; if (pre_output !== 13'd0 || pass_idx !== 4'd0) $display("FAIL basic_p0 got=%0d/%0d exp=0/0", pre_output, pass_idx); else pass_cnt++;
    put(14'd20, 1'b0);
    total_cnt++; if (pre_output !== 13'd10 || pass_idx !== 4'd1) $display("FAIL basic_p1 got=%0d/%0d exp=10/1", pre_output, pass_idx); else pass_cnt++;
    put(14'd30, 1'b0);
    total_cnt++; if (pre_output !== 13'd20 || pass_idx !== 4'd2 || in_ready !== 1'b1) $display("FAIL basic_p2 got=%0d/%0d/%0b exp=20/2/1", pre_output, pass_idx, in_ready); else pass_cnt++;
    idle();
    total_cnt++; if (res_valid !== 1'b1 || res_data !== 13'd30 || res_sat !== 1'b0) $display("FAIL basic_result got=%0b/%0d/%0b exp=1/30/0", res_valid, res_data, res_sat); else pass_cnt++;
    total_cnt++; if (pre_output !== 13'd0 || pass_idx !== 4'd0) $display("FAIL basic_wrap got=%0d/%0d exp=0/0", pre_output, pass_idx); else pass_cnt++;
    idle();
    total_cnt++; if (res_valid !== 1'b0) $display("FAIL basic_drained got=%0b exp=0", res_valid); else pass_cnt++;
  endtask

  task automatic test_saturation();
    res_ready = 1'b1;
    put(14'h1800, 1'b0);
    put(14'd0, 1'b0);
    total_cnt++; if (pre_output !== 13'h0FFF) $display("FAIL sat_pos_acc got=%h exp=0fff", pre_output); else pass_cnt++;
    put(14'd0, 1'b0);
    idle();
    total_cnt++; if (res_valid !== 1'b1 || res_data !== 13'd0 || res_sat !== 1'b1) $display("FAIL sat_sticky got=%0b/%h/%0b exp=1/0000/1", res_valid, res_data, res_sat); else pass_cnt++;
    put(14'd0, 1'b0);
    put(14'd0, 1'b0);
    put(14'h2000, 1'b0);
    idle();
    total_cnt++; if (res_valid !== 1'b1 || res_data !== 13'h1000 || res_sat !== 1'b1) $display("FAIL sat_neg got=%0b/%h/%0b exp=1/1000/1", res_valid, res_data, res_sat); else pass_cnt++;
    put(14'd0, 1'b0);
    put(14'd0, 1'b0);
    put(14'h3FFF, 1'b0);
    idle();
    total_cnt++; if (res_valid !== 1'b1 || res_data !== 13'h1FFF || res_sat !== 1'b0) $display("FAIL sat_code11 got=%0b/%h/%0b exp=1/1fff/0", res_valid, res_data, res_sat); else pass_cnt++;
    idle();
  endtask

  task automatic test_back_to_back();
    res_ready = 1'b0;
    put(14'd1, 1'b0); put(14'd2, 1'b0); put(14'd3, 1'b0);
    put(14'd4, 1'b0); put(14'd5, 1'b0); put(14'd6, 1'b0);
    put(14'd7, 1'b0);
    total_cnt++; if (in_ready !== 1'b1 || pass_idx !== 4'd0) $display("FAIL bp_pass0 got=%0b/%0d exp=1/0", in_ready, pass_idx); else pass_cnt++;
    put(14'd8, 1'b0);
    total_cnt++; if (in_ready !== 1'b1 || pass_idx !== 4'd1) $display("FAIL bp_pass1 got=%0b/%0d exp=1/1", in_ready, pass_idx); else pass_cnt++;
    put(14'd9, 1'b0);
    total_cnt++; if (in_ready !== 1'b0 || res_valid !== 1'b1 || res_data !== 13'd3) $display("FAIL bp_full got=%0b/%0b/%0d exp=0/1/3", in_ready, res_valid, res_data); else pass_cnt++;
    put(14'd9, 1'b0);
    total_cnt++; if (in_ready !== 1'b0 || res_data !== 13'd3 || pass_idx !== 4'd2) $display("FAIL bp_hold got=%0b/%0d/%0d exp=0/3/2", in_ready, res_data, pass_idx); else pass_cnt++;
    res_ready = 1'b1;
    #1;
    total_cnt++; if (in_ready !== 1'b0) $display("FAIL bp_no_comb_path got=%0b exp=0", in_ready); else pass_cnt++;
    put(14'd9, 1'b0);
    total_cnt++; if (in_ready !== 1'b1 || res_valid !== 1'b1 || res_data !== 13'd6) $display("FAIL bp_after_pop got=%0b/%0b/%0d exp=1/1/6", in_ready, res_valid, res_data); else pass_cnt++;
    // this edge pushes 9 while popping 6 with one entry held
    @(negedge clk);
    in_valid  = 1'b0;
    res_ready = 1'b0;
    #1;
    total_cnt++; if (res_valid !== 1'b1 || res_data !== 13'd9 || pass_idx !== 4'd0) $display("FAIL pushpop got=%0b/%0d/%0d exp=1/9/0", res_valid, res_data, pass_idx); else pass_cnt++;
    res_ready = 1'b1;
    idle();
    total_cnt++; if (res_valid !== 1'b0) $display("FAIL pushpop_count got=%0b exp=0", res_valid); else pass_cnt++;
    res_ready = 1'b0;
  endtask

  task automatic test_clear();
    res_ready = 1'b0;
    put(14'd11, 1'b0); put(14'd12, 1'b0); put(14'd13, 1'b0);
    put(14'd10, 1'b0);
    put(14'd99, 1'b1);
    total_cnt++; if (pre_output !== 13'd10 || pass_idx !== 4'd1) $display("FAIL clear_pre got=%0d/%0d exp=10/1", pre_output, pass_idx); else pass_cnt++;
    idle();
    total_cnt++; if (pre_output !== 13'd0 || pass_idx !== 4'd0) $display("FAIL clear_state got=%0d/%0d exp=0/0", pre_output, pass_idx); else pass_cnt++;
    total_cnt++; if (res_valid !== 1'b1 || res_data !== 13'd13) $display("FAIL clear_buffer got=%0b/%0d exp=1/13", res_valid, res_data); else pass_cnt++;
    put(14'd1, 1'b0); put(14'd2, 1'b0);
    put(14'd3, 1'b1);
    idle();
    total_cnt++; if (pass_idx !== 4'd0 || res_data !== 13'd13) $display("FAIL clear_last got=%0d/%0d exp=0/13", pass_idx, res_data); else pass_cnt++;
    res_ready = 1'b1;
    idle();
    total_cnt++; if (res_valid !== 1'b0) $display("FAIL clear_no_push got=%0b exp=0", res_valid); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    res_ready = 1'b0;
    put(14'd1, 1'b0); put(14'd1, 1'b0); put(14'd1, 1'b0);
    put(14'd2, 1'b0); put(14'd2, 1'b0); put(14'd2, 1'b0);
    put(14'd5, 1'b0); put(14'd6, 1'b0);
    idle();
    total_cnt++; if (pass_idx !== 4'd2 || pre_output !== 13'd6 || in_ready !== 1'b0) $display("FAIL rstmid_setup got=%0d/%0d/%0b exp=2/6/0", pass_idx, pre_output, in_ready); else pass_cnt++;
    #1 reset = 1'b1;
    #1;
    total_cnt++; if (res_valid !== 1'b0 || pre_output !== 13'd0 || pass_idx !== 4'd0 || in_ready !== 1'b1) $display("FAIL rstmid_async got=%0b/%0d/%0d/%0b exp=0/0/0/1", res_valid, pre_output, pass_idx, in_ready); else pass_cnt++;
    @(negedge clk);
    reset = 1'b0;
    res_ready = 1'b1;
    put(14'd100, 1'b0);
    total_cnt++; if (pre_output !== 13'd0) $display("FAIL rstmid_p0 got=%0d exp=0", pre_output); else pass_cnt++;
    put(14'd200, 1'b0);
    total_cnt++; if (pre_output !== 13'd100) $display("FAIL rstmid_p1 got=%0d exp=100", pre_output); else pass_cnt++;
    put(14'd300, 1'b0);
    total_cnt++; if (pre_output !== 13'd200) $display("FAIL rstmid_p2 got=%0d exp=200", pre_output); else pass_cnt++;
    idle();
    total_cnt++; if (res_valid !== 1'b1 || res_data !== 13'd300 || res_sat !== 1'b0) $display("FAIL rstmid_result got=%0b/%0d/%0b exp=1/300/0", res_valid, res_data, res_sat); else pass_cnt++;
  endtask

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    reset     = 1'b1;
    in_valid  = 1'b0;
    sum_in    = '0;
    clear     = 1'b0;
    res_ready = 1'b0;
    #3;
    test_reset();
    @(negedge clk);
    reset = 1'b0;
    test_basic();
    test_saturation();
    test_back_to_back();
    test_clear();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/mac_accum_collector.md
Name: mac_accum_collector

Overview:
- Consumer end of the MAC datapath (multiplier -> addertree_stage1/2/3 -> adder_final).
- Takes the 14-bit adder_final sum, saturates it to 13 bits signed, and returns the saturated value as pre_output to addertree_stage2 for the next pass of the same output pixel.
- After PASSES passes it retires the saturated result into a 2-entry output buffer drained over a valid/ready handshake.

Parameters:
PASSES, 3, accumulation passes per output (range 1..15)
SUM_W, 14, width of adder_final sum
OUT_W, 13, width of saturated result / pre_output
DEPTH, 2, output buffer entries

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
in_valid  in  1  operand beat presented to the MAC this cycle; sum_in valid combinationally
in_ready  out  1  beat accepted when in_valid && in_ready
sum_in  in  SUM_W  adder_final out; [13:12] overflow code, [12:0] value
clear  in  1  synchronous abort of the current accumulation
pre_output  out  OUT_W  signed feedback to addertree_stage2
pass_idx  out  4  index of the pass being accumulated, 0..PASSES-1
res_valid  out  1  output buffer head valid
res_ready  in  1  downstream accepts head
res_data  out  OUT_W  signed saturated result
res_sat  out  1  saturation occurred in any pass of this result

Behaviour:
- Saturation (combinational), sat(sum_in):
  - [13:12]==01 -> +4095 (13'h0FFF)
  - [13:12]==10 -> -4096 (13'h1000)
  - otherwise -> sum_in[12:0]
  - sat_hit = codes 01 or 10.
- State: pass counter pc (0..PASSES-1), acc register (OUT_W), sticky flag grp_sat.
- pre_output = acc, registered. acc is 0 whenever pc==0, so the first pass of every output sees 0.
- Accept when in_valid && in_ready, not last pass (pc < PASSES-1):
  - acc <= sat; pc <= pc+1; grp_sat <= grp_sat | sat_hit.
- Accept on last pass (pc == PASSES-1):
  - push {grp_sat|sat_hit, sat} into the buffer; acc <= 0; pc <= 0; grp_sat <= 0.
  - PASSES==1: every accept pushes, and pre_output stays 0.
- in_ready:
  - 1 when pc < PASSES-1.
  - On the last pass, 1 only if buffer count < DEPTH; pre-pop state, so there is no combinational path from res_ready.
- Latency: the pushed result appears on res_data/res_valid in the cycle after the accepting edge when the buffer was empty.
- Buffer:
  - FIFO order; res_valid = count != 0; res_data/res_sat reflect the head.
  - Push and pop in the same cycle -> count unchanged, order preserved.
  - Pop from empty is ignored.
  - res_data/res_sat hold their value while res_valid && !res_ready.
- clear:
  - pc <= 0, acc <= 0, grp_sat <= 0. Buffer contents are kept.
  - clear wins over a simultaneous accept: the beat is discarded and not pushed, even on the last pass.
- No in_valid -> state holds; pre_output stable.
- Reset (async, mid-operation allowed):
  - pc=0, acc=0, grp_sat=0, buffer empty.
  - Outputs: pre_output=0, pass_idx=0, res_valid=0, res_data=0, res_sat=0, in_ready=1.

Decomposition:
- Package npu_mac_pkg holds:
  - SUM_W=14, OUT_W=13
  - SAT_POS=13'sd4095, SAT_NEG=-13'sd4096
  - the sat() function and result struct {sat, data}; the same constants are used by the reference-model clip in benches.
- Sub-module mac_out_fifo: DEPTH-entry synchronous FIFO with count and full/empty, same reset.

Test Plan:
- PASSES=3, three beats sum_in=10,20,30 back-to-back, res_ready=1 -> pre_output 0,10,20 during the beats; res_data=30, res_sat=0 valid one cycle after third beat; pre_output back to 0.
- Saturation codes: sum_in=14'h1800 -> acc 4095, res_sat=1; 14'h2000 -> -4096; 14'h3FFF -> -1 with res_sat=0.
- Backpressure: res_ready=0, complete 2 outputs (buffer full); third group's last beat sees in_ready=0 while passes 0..1 are still accepted; raise res_ready -> head pops, in_ready=1 next cycle, FIFO order 1st,2nd,3rd.
- Simultaneous push/pop with count=1 -> count stays 1, data order correct.
- clear asserted with in_valid on pass 1 (acc=10) -> beat dropped, pc=0, pre_output=0, buffered results unchanged.
- reset asserted mid-group (pc=2) and with a full buffer -> immediately res_valid=0, pre_output=0, pass_idx=0; next group accumulates from 0.
